sram_bridge: RTL and testbench
==============================

SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 SHALL have parameter WAIT, default 2, meaning SRAM cycles per halfword access minus one (legal 1..7).
REQ-002 SHALL have port clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port cyc_i  in  1  bus cycle request from initiator, held until ack_o.
REQ-005 SHALL have port we_i  in  1  1 = write, 0 = read.
REQ-006 SHALL have port adr_i  in  32  byte address; bits [20:2] used.
REQ-007 SHALL have port sel_i  in  4  byte-lane enables, sel_i[3] = dat[31:24].
REQ-008 SHALL have port dat_i  in  32  write data.
REQ-009 SHALL have port dat_o  out  32  read data, registered.
REQ-010 SHALL have port ack_o  out  1  one-cycle completion strobe.
REQ-011 SHALL have ports sram_addr out 20, sram_dq_o out 16, sram_dq_i in 16, sram_dq_oe out 1 (drive enable), sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n out 1 each (active-low).

Function
REQ-012 SHALL use states IDLE, HI, LO, ACK.
REQ-013 SHALL, in IDLE with cyc_i=1, latch we_i/adr_i/sel_i/dat_i; go to HI if sel_i[3:2]!=0, else LO if sel_i[1:0]!=0, else ACK.
REQ-014 SHALL map lane [31:16] to sram_addr={adr_i[20:2],0} and lane [15:0] to {adr_i[20:2],1} (big-endian).
REQ-015 SHALL drive ub_n/lb_n as ~sel[3]/~sel[2] in HI and ~sel[1]/~sel[0] in LO.
REQ-016 SHALL hold each of HI and LO for exactly WAIT+1 cycles, timed by a 3-bit counter cleared on entry.
REQ-017 SHALL go HI->LO if sel[1:0]!=0, else HI->ACK; LO->ACK.
REQ-018 SHALL, on write, keep ce_n=0 and dq_oe=1 for the whole phase, and we_n=0 for the first WAIT cycles and 1 in the last (data hold); oe_n=1.
REQ-019 SHALL, on read, keep ce_n=0 and oe_n=0 for the whole phase, we_n=1, dq_oe=0, and capture sram_dq_i into the matching dat_o half at the edge ending the phase.
REQ-020 SHALL zero the unselected 16-bit half of dat_o when a read starts; dat_o holds otherwise, including across writes.
REQ-021 SHALL assert ack_o only in ACK, for one cycle, then return to IDLE.
REQ-022 SHALL produce ack_o exactly n*(WAIT+1)+1 cycles after the IDLE edge accepting the request (n = halves accessed, 0..2).
REQ-023 SHALL treat cyc_i=1 in IDLE the cycle after ACK as a new request (initiator drops cyc_i on ack).
REQ-024 SHALL, if cyc_i falls in HI or LO, abort to IDLE next edge: strobes inactive, dq_oe=0, no ack_o.
REQ-025 SHALL drive strobes inactive (all _n=1) and dq_oe=0 in IDLE and ACK.

Reset
REQ-026 SHALL, while rst_i=1 at an edge, enter IDLE; ack_o=0, dat_o=0, sram_addr=0, sram_dq_o=0, dq_oe=0, all _n outputs 1; applies mid-access.

Structure
REQ-027 SHALL place the state enum and WAIT default in shared package sram_bridge_pkg.
REQ-028 SHALL be one module, no sub-modules; all outputs registered.

Verification
REQ-029 Read, sel=1111, adr=0x10, WAIT=2, SRAM 0x8 -> 0xDEAD, 0x9 -> 0xBEEF -> dat_o=0xDEADBEEF, ack_o 7 cycles after accept.
REQ-030 Write, sel=0100, dat_i=0x00AB0000, adr=0x20 -> one HI phase at sram_addr 0x10, ub_n=1, lb_n=0, we_n low 2 cycles, ack at 4.
REQ-031 Read, sel=0011 -> only LO phase, dat_o[31:16]=0, ack at 4; sel=0000 -> no strobes, ack at 1.
REQ-032 Back-to-back: write then read at same address with cyc_i held high -> second accepted the cycle after ack, reads back written data.
REQ-033 cyc_i dropped in cycle 2 of HI -> no ack, strobes inactive next cycle; rst_i asserted mid-LO write -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/sram_bridge_pkg.sv
// sram_bridge_pkg: shared FSM state encoding and default SRAM wait setting.
package sram_bridge_pkg;
  typedef enum logic [1:0] {IDLE, HI, LO, ACK} state_e;
  localparam int DEF_WAIT = 2;
endpackage

// File: rtl/sram_bridge.sv
// sram_bridge: 32-bit bus to 16-bit async SRAM bridge, big-endian halfword split.
module sram_bridge
  import sram_bridge_pkg::*;
#(
  parameter int WAIT = DEF_WAIT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        we_i,
  input  logic [31:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [18:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] dq_q, dq_d;
  logic        dqoe_q, dqoe_d;
  logic        ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic        last, ph, lo;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adr_d   = adr_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    dat_d   = dat_q;
    last    = cnt_q == 3'(WAIT);
    unique case (state_q)
      IDLE: if (cyc_i) begin
        we_d    = we_i;
        adr_d   = adr_i[20:2];
        sel_d   = sel_i;
        wdat_d  = dat_i;
        cnt_d   = 3'd0;
        state_d = |sel_i[3:2] ? HI : |sel_i[1:0] ? LO : ACK;
        if (!we_i && !(|sel_i[3:2])) dat_d[31:16] = 16'h0;
        if (!we_i && !(|sel_i[1:0])) dat_d[15:0] = 16'h0;
      end
      HI: if (!cyc_i) state_d = IDLE;
        else if (last) begin
          cnt_d   = 3'd0;
          state_d = |sel_q[1:0] ? LO : ACK;
          if (!we_q) dat_d[31:16] = sram_dq_i;
        end else cnt_d = cnt_q + 3'd1;
      LO: if (!cyc_i) state_d = IDLE;
        else if (last) begin
          state_d = ACK;
          if (!we_q) dat_d[15:0] = sram_dq_i;
        end else cnt_d = cnt_q + 3'd1;
      default: state_d = IDLE;
    endcase
    // outputs are registered, so they are derived from the state being entered
    ph     = state_d == HI || state_d == LO;
    lo     = state_d == LO;
    ack_d  = state_d == ACK;
    addr_d = ph ? {adr_d, lo} : addr_q;
    dq_d   = ph ? (lo ? wdat_d[15:0] : wdat_d[31:16]) : dq_q;
    dqoe_d = ph && we_d;
    ce_n_d = !ph;
    oe_n_d = !(ph && !we_d);
    we_n_d = !(ph && we_d && cnt_d != 3'(WAIT));
    ub_n_d = !(ph && (lo ? sel_d[1] : sel_d[3]));
    lb_n_d = !(ph && (lo ? sel_d[0] : sel_d[2]));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      adr_q   <= 19'h0;
      sel_q   <= 4'h0;
      wdat_q  <= 32'h0;
      dat_q   <= 32'h0;
      ack_q   <= 1'b0;
      addr_q  <= 20'h0;
      dq_q    <= 16'h0;
      dqoe_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      dqoe_q  <= dqoe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end
  assign dat_o      = dat_q;
  assign ack_o      = ack_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = dq_q;
  assign sram_dq_oe = dqoe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed checks of sram_bridge against a small SRAM model.
module tb_sram_bridge;
  logic        clk = 1'b0;
  logic        rst_i, cyc_i, we_i;
  logic [31:0] adr_i, dat_i, dat_o;
  logic [3:0]  sel_i;
  logic        ack_o;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
  logic [15:0] mem [64];
  int total = 0, bad = 0;
  int lat, ce_lo, oe_lo, we_lo, ub_lo, lb_lo, oe_hi_cnt, acks;
  logic [19:0] first_addr;

  sram_bridge dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .we_i(we_i), .adr_i(adr_i),
    .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 16'h0;

  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
      mem[8]     <= 16'hDEAD;
      mem[9]     <= 16'hBEEF;
      mem[6'h10] <= 16'h1200;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) mem[sram_addr[5:0]][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n) mem[sram_addr[5:0]][7:0]  <= sram_dq_o[7:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input bit w, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input bit keep);
    cyc_i = 1'b1; we_i = w; adr_i = a; sel_i = s; dat_i = d;
    lat = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; ub_lo = 0; lb_lo = 0; oe_hi_cnt = 0;
    first_addr = 20'hFFFFF;
    do begin
      tick();
      lat++;
      if (!sram_ce_n) begin
        ce_lo++;
        if (first_addr == 20'hFFFFF) first_addr = sram_addr;
      end
      if (!sram_oe_n) oe_lo++;
      if (!sram_we_n) we_lo++;
      if (!sram_ub_n) ub_lo++;
      if (!sram_lb_n) lb_lo++;
      if (sram_dq_oe) oe_hi_cnt++;
    end while (!ack_o && lat < 40);
    if (!keep) cyc_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"}, {31'h0, ack_o}, 32'h0);
    chk({tag, "_dat"}, dat_o, 32'h0);
    chk({tag, "_addr"}, {12'h0, sram_addr}, 32'h0);
    chk({tag, "_dq"}, {16'h0, sram_dq_o}, 32'h0);
    chk({tag, "_strobes"}, {26'h0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
        32'h1F);
  endtask

  initial begin
    rst_i = 1'b1; cyc_i = 1'b0; we_i = 1'b0; adr_i = 32'h0; sel_i = 4'h0; dat_i = 32'h0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_i = 1'b0;
    tick();

    run(1'b0, 32'h10, 4'hF, 32'h0, 1'b0);
    chk("rd_full_lat", lat, 7);
    chk("rd_full_dat", dat_o, 32'hDEADBEEF);
    chk("rd_full_ce", ce_lo, 6);
    chk("rd_full_oe", oe_lo, 6);
    chk("rd_full_we", we_lo, 0);
    chk("rd_full_addr", {12'h0, first_addr}, 32'h8);
    tick();
    chk("rd_full_ack_1cyc", {31'h0, ack_o}, 32'h0);

    run(1'b1, 32'h20, 4'b0100, 32'h00AB0000, 1'b0);
    chk("wr_hi_lat", lat, 4);
    chk("wr_hi_addr", {12'h0, first_addr}, 32'h10);
    chk("wr_hi_ce", ce_lo, 3);
    chk("wr_hi_we", we_lo, 2);
    chk("wr_hi_ub", ub_lo, 0);
    chk("wr_hi_lb", lb_lo, 3);
    chk("wr_hi_dqoe", oe_hi_cnt, 3);
    chk("wr_hi_oe", oe_lo, 0);
    chk("wr_hi_dat_hold", dat_o, 32'hDEADBEEF);
    tick();
    chk("wr_hi_mem", {16'h0, mem[6'h10]}, 32'h12AB);

    run(1'b0, 32'h10, 4'b0011, 32'h0, 1'b0);
    chk("rd_lo_lat", lat, 4);
    chk("rd_lo_addr", {12'h0, first_addr}, 32'h9);
    chk("rd_lo_dat", dat_o, 32'h0000BEEF);
    tick();

    run(1'b0, 32'h10, 4'b0000, 32'h0, 1'b0);
    chk("rd_none_lat", lat, 1);
    chk("rd_none_ce", ce_lo, 0);
    tick();

    run(1'b1, 32'h40, 4'hF, 32'hCAFEF00D, 1'b1);
    chk("b2b_wr_lat", lat, 7);
    we_i = 1'b0; dat_i = 32'h0;
    tick();
    chk("b2b_gap_ack", {31'h0, ack_o}, 32'h0);
    chk("b2b_gap_ce", {31'h0, sram_ce_n}, 32'h1);
    run(1'b0, 32'h40, 4'hF, 32'h0, 1'b0);
    chk("b2b_rd_lat", lat, 7);
    chk("b2b_rd_dat", dat_o, 32'hCAFEF00D);
    tick();

    cyc_i = 1'b1; we_i = 1'b0; adr_i = 32'h10; sel_i = 4'hF;
    tick();
    tick();
    chk("abort_in_hi", {31'h0, sram_ce_n}, 32'h0);
    cyc_i = 1'b0;
    tick();
    chk("abort_strobes", {26'h0, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
        32'h1F);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      if (ack_o) acks++;
      tick();
    end
    chk("abort_no_ack", acks, 0);

    cyc_i = 1'b1; we_i = 1'b1; adr_i = 32'h10; sel_i = 4'b0011; dat_i = 32'h00001234;
    tick();
    tick();
    chk("rst_mid_lo_we", {31'h0, sram_we_n}, 32'h0);
    rst_i = 1'b1;
    tick();
    check_reset_vals("rst_mid");
    rst_i = 1'b0; cyc_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
